fetch_btb: RTL

- Instruction-fetch stage: owns the PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Drives the instruction-memory address and feeds the IF/ID pipeline register with PCPlus4, FindinBTB and taken.
- Accepts redirects from later stages (exception, branch resolved in ID, BTB misprediction recovery) and BTB training updates from ID.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/btb_array.sv | 68 ++++++
 rtl/fetch_btb.sv | 69 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect-select bit positions, BTB counter encodings
// and default fetch addresses.
package cpu_pkg;

  localparam int PCSRC_EXC  = 0;
  localparam int PCSRC_BR   = 1;
  localparam int PCSRC_MISP = 2;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_0180;

  // 2-bit saturating counter step toward the observed outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic outcome);
    if (outcome) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else         return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer: combinational lookup by word address,
// registered training update. Lookups always see pre-update contents.
module btb_array
  import cpu_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] rd_addr,
  output logic        hit,
  output logic [1:0]  ctr,
  output logic [31:0] target,
  input  logic        upd_valid,
  input  logic [29:0] upd_addr,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic              valid_mem  [ENTRIES];
  logic [1:0]        ctr_mem    [ENTRIES];
  logic [TAG_W-1:0]  tag_mem    [ENTRIES];
  logic [31:0]       target_mem [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0]    rd_tag, upd_tag;
  logic                upd_hit;

  assign rd_idx  = rd_addr[IDX_BITS-1:0];
  assign rd_tag  = rd_addr[29:IDX_BITS];
  assign upd_idx = upd_addr[IDX_BITS-1:0];
  assign upd_tag = upd_addr[29:IDX_BITS];

  assign hit     = valid_mem[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign ctr     = ctr_mem[rd_idx];
  assign target  = target_mem[rd_idx];
  assign upd_hit = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // NOTE: only valid bits and counters are reset; tag and target storage is
  // never read while its valid bit is clear, so it is left without a reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_mem[i] <= 1'b0;
        ctr_mem[i]   <= WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_mem[upd_idx] <= ctr_next(ctr_mem[upd_idx], upd_taken);
      end else if (upd_taken) begin
        valid_mem[upd_idx] <= 1'b1;
        ctr_mem[upd_idx]   <= WT;
      end
    end
  end

  // A taken outcome writes tag and target on both hit (tag unchanged) and allocation.
  always_ff @(posedge clk) begin
    if (reset && upd_valid && upd_taken) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_btb.sv
// Instruction-fetch stage: PC register, next-PC selection and BTB-based
// prediction feeding the IF/ID register.
module fetch_btb
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEFAULT_EXC_VEC,
  parameter int          IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] RecoverPC,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FindinBTB,
  output logic        taken,
  output logic [31:0] PredTarget
);

  logic [1:0]  btb_ctr;
  logic [31:0] btb_target;
  logic [31:0] next_pc;
  logic        unused_ok;

  assign unused_ok = ^upd_pc[1:0];

  btb_array #(.IDX_BITS(IDX_BITS)) u_btb (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (PC[31:2]),
    .hit        (FindinBTB),
    .ctr        (btb_ctr),
    .target     (btb_target),
    .upd_valid  (upd_valid),
    .upd_addr   (upd_pc[31:2]),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );

  assign PCPlus4    = PC + 32'd4;
  assign taken      = FindinBTB && btb_ctr[1];
  assign PredTarget = taken ? btb_target : 32'h0;

  // Redirects outrank the stall so a redirect is never lost while PC_Write is low.
  // NOTE: every path assigns next_pc, so this combinational block cannot infer a latch.
  always_comb begin
    next_pc = PCPlus4;
    if      (PCSrc[PCSRC_EXC])  next_pc = EXC_VEC;
    else if (PCSrc[PCSRC_MISP]) next_pc = RecoverPC;
    else if (PCSrc[PCSRC_BR])   next_pc = BranchAddr;
    else if (!PC_Write)         next_pc = PC;
    else if (taken)             next_pc = PredTarget;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) PC <= RESET_PC;
    else        PC <= next_pc;
  end

endmodule
